// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: MEM/WB writebacks always win, mul/div results queue in a FIFO and
// drain in idle slots. Define WBARB_STARVE_EN to build the starvation counter that drives stall_req.
module wb_port_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWrite_in,
    input  logic        MemtoReg_in,
    input  logic [31:0] read_data_in,
    input  logic [31:0] alu_result_in,
    input  logic [4:0]  rd_in,
    input  logic        md_valid,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_data,
    output logic        md_ready,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    output logic        md_pending_hit,
    output logic        stall_req,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_param_check
        $error("wb_port_arbiter: DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
    end

    logic [4:0]    ent_rd   [DEPTH];
    logic [31:0]   ent_data [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic pipe_wr;
    logic empty;
    logic full;
    logic push;
    logic pop;

    // md_valid/md_ready: a result transfers on a cycle where both are high; md_ready
    // comes from registered count only, so the producer may hold md_valid while stalled.
    assign pipe_wr  = RegWrite_in && (rd_in != 5'd0);
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign md_ready = !full;
    assign push     = md_valid && md_ready && (md_rd != 5'd0);
    assign pop      = !pipe_wr && !empty;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (pipe_wr) begin
            rf_we    = 1'b1;
            rf_waddr = rd_in;
            rf_wdata = MemtoReg_in ? read_data_in : alu_result_in;
        end else if (!empty) begin
            rf_we    = 1'b1;
            rf_waddr = ent_rd[rd_ptr];
            rf_wdata = ent_data[rd_ptr];
        end
    end

    // Entry storage carries no reset; validity is defined by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_rd[wr_ptr]   <= md_rd;
            ent_data[wr_ptr] <= md_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // An entry is live when its distance from the head, modulo DEPTH, is below count.
    always_comb begin
        logic [PW-1:0] off;
        logic          live;
        md_pending_hit = 1'b0;
        off            = '0;
        live           = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            off  = PW'(i) - rd_ptr;
            live = ({1'b0, off} < count);
            if (live && id_rs1 != 5'd0 && ent_rd[i] == id_rs1) md_pending_hit = 1'b1;
            if (live && id_rs2 != 5'd0 && ent_rd[i] == id_rs2) md_pending_hit = 1'b1;
        end
    end

`ifdef WBARB_STARVE_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_cnt_nxt;

    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (pop || empty) begin
            starve_cnt_nxt = '0;
        end else if (pipe_wr && starve_cnt != SW'(STARVE_LIMIT)) begin
            starve_cnt_nxt = starve_cnt + SW'(1);
        end
    end

    // stall_req rises with the edge that saturates the counter and falls with the next pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else begin
            starve_cnt <= starve_cnt_nxt;
            if (pop) begin
                stall_req <= 1'b0;
            end else if (starve_cnt_nxt == SW'(STARVE_LIMIT)) begin
                stall_req <= 1'b1;
            end
        end
    end
`else
    assign stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a per-cycle vector table plus hand sequences for
// starvation/bubble handling and reset in mid-operation.
module tb_wb_port_arbiter;

`ifdef WBARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        RegWrite_in;
    logic        MemtoReg_in;
    logic [31:0] read_data_in;
    logic [31:0] alu_result_in;
    logic [4:0]  rd_in;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        md_ready;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        md_pending_hit;
    logic        stall_req;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        re;
        logic        m2r;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        mdv;
        logic [4:0]  mdrd;
        logic [31:0] mdd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        ready;
        logic        hit;
    } vec_t;

    vec_t vecs[$];

    wb_port_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .RegWrite_in    (RegWrite_in),
        .MemtoReg_in    (MemtoReg_in),
        .read_data_in   (read_data_in),
        .alu_result_in  (alu_result_in),
        .rd_in          (rd_in),
        .md_valid       (md_valid),
        .md_rd          (md_rd),
        .md_data        (md_data),
        .md_ready       (md_ready),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .md_pending_hit (md_pending_hit),
        .stall_req      (stall_req),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkv(input logic re, input logic m2r, input logic [31:0] rdata,
                                 input logic [31:0] alu, input logic [4:0] rd, input logic mdv,
                                 input logic [4:0] mdrd, input logic [31:0] mdd,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic we,
                                 input logic [4:0] waddr, input logic [31:0] wdata,
                                 input logic ready, input logic hit);
        vec_t v;
        v.re = re; v.m2r = m2r; v.rdata = rdata; v.alu = alu; v.rd = rd;
        v.mdv = mdv; v.mdrd = mdrd; v.mdd = mdd; v.rs1 = rs1; v.rs2 = rs2;
        v.we = we; v.waddr = waddr; v.wdata = wdata; v.ready = ready; v.hit = hit;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        RegWrite_in   = v.re;
        MemtoReg_in   = v.m2r;
        read_data_in  = v.rdata;
        alu_result_in = v.alu;
        rd_in         = v.rd;
        md_valid      = v.mdv;
        md_rd         = v.mdrd;
        md_data       = v.mdd;
        id_rs1        = v.rs1;
        id_rs2        = v.rs2;
    endtask

    task automatic check_outs(input vec_t v, input logic exp_stall, input string tag);
        check({tag, ".rf_we"},    32'(rf_we),          32'(v.we));
        check({tag, ".rf_waddr"}, 32'(rf_waddr),       32'(v.waddr));
        check({tag, ".rf_wdata"}, rf_wdata,            v.wdata);
        check({tag, ".md_ready"}, 32'(md_ready),       32'(v.ready));
        check({tag, ".hit"},      32'(md_pending_hit), 32'(v.hit));
        check({tag, ".stall"},    32'(stall_req),      32'(exp_stall));
    endtask

    // Called at posedge+1: drive, sample at the falling edge, then move to the next posedge+1.
    task automatic step(input vec_t v, input logic exp_stall, input string tag);
        drive(v);
        #4;
        check_outs(v, exp_stall, tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t idle;
        idle = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        //        re m2r rdata         alu           rd  mdv mdrd mdd          rs1 rs2 we waddr wdata         rdy hit
        vecs.push_back(mkv(0, 0, 32'h0,        32'h0,        0,  0, 0,  32'h0,        0,  0,  0, 0,  32'h0,        1, 0));
        vecs.push_back(mkv(1, 1, 32'hDEADBEEF, 32'h11111111, 5,  0, 0,  32'h0,        0,  0,  1, 5,  32'hDEADBEEF, 1, 0));
        vecs.push_back(mkv(1, 0, 32'h55,       32'hAA,       9,  0, 0,  32'h0,        0,  0,  1, 9,  32'hAA,       1, 0));
        vecs.push_back(mkv(1, 0, 32'h0,        32'h33,       3,  1, 7,  32'h12,       7,  0,  1, 3,  32'h33,       1, 0));
        vecs.push_back(mkv(1, 0, 32'h0,        32'h34,       3,  0, 0,  32'h0,        7,  0,  1, 3,  32'h34,       1, 1));
        vecs.push_back(mkv(0, 0, 32'h0,        32'h0,        0,  0, 0,  32'h0,        7,  0,  1, 7,  32'h12,       1, 1));
        vecs.push_back(mkv(0, 0, 32'h0,        32'h0,        0,  0, 0,  32'h0,        7,  0,  0, 0,  32'h0,        1, 0));
        vecs.push_back(mkv(0, 0, 32'h0,        32'h0,        0,  1, 0,  32'h99,       0,  0,  0, 0,  32'h0,        1, 0));
        vecs.push_back(mkv(1, 0, 32'h0,        32'h77,       0,  1, 12, 32'hC0FFEE,   0,  0,  0, 0,  32'h0,        1, 0));
        vecs.push_back(mkv(1, 0, 32'h0,        32'h77,       0,  0, 0,  32'h0,        0,  12, 1, 12, 32'hC0FFEE,   1, 1));
        vecs.push_back(mkv(0, 0, 32'h0,        32'h0,        0,  0, 0,  32'h0,        0,  12, 0, 0,  32'h0,        1, 0));
        vecs.push_back(mkv(1, 0, 32'h0,        32'h101,      1,  1, 16, 32'hA0,       0,  0,  1, 1,  32'h101,      1, 0));
        vecs.push_back(mkv(1, 0, 32'h0,        32'h102,      1,  1, 17, 32'hA1,       0,  0,  1, 1,  32'h102,      1, 0));
        vecs.push_back(mkv(1, 0, 32'h0,        32'h103,      1,  1, 18, 32'hA2,       0,  0,  1, 1,  32'h103,      1, 0));
        vecs.push_back(mkv(1, 0, 32'h0,        32'h104,      1,  1, 19, 32'hA3,       0,  0,  1, 1,  32'h104,      1, 0));
        vecs.push_back(mkv(1, 0, 32'h0,        32'h105,      1,  1, 20, 32'hA4,       19, 0,  1, 1,  32'h105,      0, 1));
        vecs.push_back(mkv(0, 0, 32'h0,        32'h0,        0,  1, 20, 32'hA4,       0,  0,  1, 16, 32'hA0,       0, 0));
        vecs.push_back(mkv(1, 0, 32'h0,        32'h107,      1,  1, 20, 32'hA4,       20, 0,  1, 1,  32'h107,      1, 0));
        vecs.push_back(mkv(0, 0, 32'h0,        32'h0,        0,  0, 0,  32'h0,        20, 0,  1, 17, 32'hA1,       0, 1));
        vecs.push_back(mkv(0, 0, 32'h0,        32'h0,        0,  1, 21, 32'hA5,       0,  0,  1, 18, 32'hA2,       1, 0));
        vecs.push_back(mkv(0, 0, 32'h0,        32'h0,        0,  0, 0,  32'h0,        0,  0,  1, 19, 32'hA3,       1, 0));
        vecs.push_back(mkv(0, 0, 32'h0,        32'h0,        0,  0, 0,  32'h0,        20, 0,  1, 20, 32'hA4,       1, 1));
        vecs.push_back(mkv(0, 0, 32'h0,        32'h0,        0,  0, 0,  32'h0,        21, 0,  1, 21, 32'hA5,       1, 1));
        vecs.push_back(mkv(0, 0, 32'h0,        32'h0,        0,  0, 0,  32'h0,        21, 0,  0, 0,  32'h0,        1, 0));

        // Reset held low with idle inputs.
        rst = 1'b0;
        drive(idle);
        #12;
        check_outs(idle, 1'b0, "reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], 1'b0, $sformatf("v%0d", i));
        end

        // Reset in mid-operation discards a buffered result.
        step(mkv(0, 0, 0, 0, 0, 1, 30, 32'h30, 30, 0, 0, 0, 0, 1, 0), 1'b0, "mrst_push");
        drive(mkv(0, 0, 0, 0, 0, 0, 0, 0, 30, 0, 0, 0, 0, 1, 0));
        rst = 1'b0;
        #4;
        check_outs(mkv(0, 0, 0, 0, 0, 0, 0, 0, 30, 0, 0, 0, 0, 1, 0), 1'b0, "mrst_low");
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 30, 0, 0, 0, 0, 1, 0), 1'b0, "mrst_after");

        // Starvation: one buffered entry blocked by continuous pipeline writes.
        step(mkv(0, 0, 0, 0, 0, 1, 25, 32'h2525, 0, 0, 0, 0, 0, 1, 0), 1'b0, "stv_push");
        for (int k = 1; k <= 8; k++) begin
            step(mkv(1, 0, 0, 32'(k), 2, 0, 0, 0, 25, 0, 1, 2, 32'(k), 1, 1), 1'b0,
                 $sformatf("stv_w%0d", k));
        end
        step(mkv(1, 0, 0, 32'h9, 2, 0, 0, 0, 25, 0, 1, 2, 32'h9, 1, 1), STARVE_ON, "stv_req");
        step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 25, 0, 1, 25, 32'h2525, 1, 1), STARVE_ON, "stv_bubble");
        step(mkv(0, 0, 0, 0, 0, 0, 0, 0, 25, 0, 0, 0, 0, 1, 0), 1'b0, "stv_clear");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline writeback path (fed by the MEM/WB pipeline register) and results returned by the long-latency multiply/divide unit. Pipeline writebacks always take the port in the cycle they arrive. Multiply/divide results are buffered in a small FIFO and drained in idle writeback slots. A starvation counter can request a pipeline bubble so buffered results are eventually written. The block sits between MEM/WB, the mul/div unit, the register file and the hazard unit.

## Interface
Parameters:
- DEPTH, 4 — mul/div result FIFO entries; power of two, ≥2
- STARVE_LIMIT, 8 — consecutive lost slots with a non-empty FIFO before a bubble is requested; ≥1

Ports:
- clk  in  1  — single clock, rising edge
- rst  in  1  — asynchronous, active-low reset
- RegWrite_in  in  1  — pipeline writeback enable (from MEM/WB)
- MemtoReg_in  in  1  — 1: write read_data_in, 0: write alu_result_in
- read_data_in  in  32  — load data from MEM/WB
- alu_result_in  in  32  — ALU result from MEM/WB
- rd_in  in  5  — pipeline destination register
- md_valid  in  1  — mul/div result valid
- md_rd  in  5  — mul/div destination register
- md_data  in  32  — mul/div result
- md_ready  out  1  — FIFO can accept; equals !full
- id_rs1, id_rs2  in  5 each  — ID-stage source registers for the pending check
- md_pending_hit  out  1  — a nonzero id_rs1 or id_rs2 matches the rd of any valid FIFO entry
- stall_req  out  1  — registered bubble request to the hazard unit
- rf_we  out  1  — register-file write enable
- rf_waddr  out  5  — register-file write address
- rf_wdata  out  32  — register-file write data

## Operation
- Pipeline slot active: pipe_wr = RegWrite_in && rd_in != 0. Writes to x0 count as idle slots.
- Port select, combinational:
  - If pipe_wr: rf_we=1, rf_waddr=rd_in, rf_wdata = MemtoReg_in ? read_data_in : alu_result_in.
  - Else if FIFO non-empty: write the FIFO head and pop it in the same cycle.
  - Else: rf_we=0, rf_waddr=0, rf_wdata=0.
- Enqueue: on md_valid && md_ready, push {md_rd, md_data}. Results with md_rd==0 are accepted and dropped, not pushed.
- FIFO: circular buffer with rd/wr pointers and count (width clog2(DEPTH)+1). Pointers wrap modulo DEPTH.
- Full FIFO: md_ready=0, so no push can occur.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Results are never reordered. The hazard unit uses md_pending_hit to prevent any WAW or RAW conflict against buffered entries; the arbiter does no rd conflict checks.
- Starvation counter starve_cnt:
  - Clears on any pop or when the FIFO is empty.
  - Otherwise increments, saturating at STARVE_LIMIT, each cycle pipe_wr blocks a non-empty FIFO.
- stall_req: set at the clock edge where starve_cnt reaches STARVE_LIMIT. Held until the edge at which a pop occurs, then cleared.

## Timing
- Reset values (async, rst low): FIFO empty, pointers/count/starve_cnt = 0, stall_req=0, md_ready=1, md_pending_hit=0. rf_* follow the combinational rules with an empty FIFO.
- Pipeline write: zero added latency; rf_* are valid in the same cycle as the MEM/WB outputs.
- Mul/div result: pushed at edge t, earliest register-file write in cycle t+1.
- md_ready and md_pending_hit depend only on registered state, with no combinational path from md_valid.
- stall_req: one cycle after the limit-reaching edge. The bubble arrives in MEM/WB at least one cycle later; that cycle pops and clears stall_req.
- Reset asserted mid-operation: buffered results are discarded; the mul/div unit and pipeline are reset together.

## Configuration
- WBARB_STARVE_EN defined: starve_cnt and stall_req are implemented as above.
- WBARB_STARVE_EN undefined: no counter; stall_req is tied to 0. The FIFO drains only in naturally idle slots; backpressure is through md_ready alone.

## Test plan
- Reset with rst=0, then release → md_ready=1, stall_req=0. With RegWrite_in=0, rf_we=0.
- RegWrite_in=1, MemtoReg_in=1, rd_in=5, read_data_in=0xDEADBEEF → same cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
- Push md {rd=7, 0x12} while pipeline writes rd=3 for 2 cycles, then idle → rf writes rd 3, rd 3, then rd 7 = 0x12. md_pending_hit=1 for id_rs1=7 until the pop.
- Push 4 results with the pipeline continuously writing → md_ready=0 after the 4th. Next push is held until a pop. FIFO order is preserved across pointer wrap.
- With WBARB_STARVE_EN, FIFO non-empty and 8 consecutive pipeline writes → stall_req=1 on the next cycle. Bubble slot pops one entry and clears stall_req.
- md_rd=0 push, and pipeline rd_in=0 with RegWrite_in=1 → no FIFO entry. The slot is treated as idle and the FIFO head is written instead.
